ioctl_upload: RTL and testbench
===============================

Name: ioctl_upload

Overview:
- Serves HPS-initiated uploads (save files, e.g. high-score/NVRAM) by reading bytes from a game-side RAM and returning them on the ioctl upload data path.
- This is the read direction of the ioctl transfer protocol, complementary to the ROM/DIP download path.
- Sits in the top level between hps_io and the game core.
- Freezes the game core for a coherent snapshot, reads the RAM through an arbitrated request/acknowledge port, and stalls the HPS with ioctl_wait until each byte is valid.

Parameters:
- INDEX, 4: ioctl_index value this block responds to.
- SIZE, 1024: number of bytes in the save region (payload length).
- ADDR_WIDTH, 10: width of ram_addr; SIZE <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  high for the duration of an HPS upload.
- ioctl_index  in  8  file index of the current transfer.
- ioctl_addr  in  25  byte address requested by the HPS.
- ioctl_rd  in  1  single-cycle read strobe; ioctl_addr is valid with it.
- ioctl_din  out  8  byte returned to the HPS.
- ioctl_wait  out  1  stalls the HPS while a byte is being fetched.
- pause_req  out  1  requests the game core to halt.
- pause_ack  in  1  game core is halted.
- ram_addr  out  ADDR_WIDTH  game RAM byte address.
- ram_rd  out  1  read request; held until ram_ack.
- ram_ack  in  1  single-cycle strobe; ram_q is valid in the same cycle.
- ram_q  in  8  game RAM read data.
- busy  out  1  high from the start of a matching upload until return to IDLE.

Behaviour:
- The module is active only when ioctl_upload=1 and ioctl_index==INDEX (call this "match"). All other indices are ignored; outputs stay at reset values.
- Reset values: ioctl_din=0, ioctl_wait=0, pause_req=0, ram_rd=0, ram_addr=0, busy=0. FSM state is IDLE.
- IDLE:
  - Rising match -> PAUSE.
  - Set busy=1, pause_req=1, ioctl_wait=1.
- PAUSE:
  - Hold until pause_ack=1, then -> READY and deassert ioctl_wait.
  - The HPS is stalled, so no rd is lost.
- READY:
  - ioctl_rd with ioctl_addr < SIZE -> FETCH. In the same cycle: ram_addr=ioctl_addr[ADDR_WIDTH-1:0], ram_rd=1, ioctl_wait=1.
  - ioctl_rd with ioctl_addr >= SIZE -> ioctl_din=8'hFF on the next cycle, ioctl_wait stays 0, state stays READY.
- FETCH:
  - Hold ram_rd and ram_addr stable until ram_ack.
  - On ram_ack: latch ioctl_din<=ram_q, ram_rd<=0, ioctl_wait<=0 (next cycle), -> READY.
  - Read latency is 1 + arbitration cycles; with ram_ack tied high in the first FETCH cycle, ioctl_wait is high for exactly 2 cycles.
- ioctl_rd arriving while ioctl_wait=1 is a protocol violation; it is ignored.
- Upload end (match falls) in any state:
  - Abort any pending fetch: ram_rd<=0 next cycle; a late ram_ack is ignored.
  - pause_req<=0, ioctl_wait<=0, busy<=0 -> IDLE.
- Every state always releases pause_req when the upload ends, so the game never stays frozen.
- reset mid-transfer: all outputs return to reset values on the next clock. The HPS must not be left stalled: ioctl_wait=0.
- Address width: bits of ioctl_addr above ADDR_WIDTH participate only in the >= SIZE compare.

Optional Feature:
- IOCTL_UPLOAD_CHECKSUM_EN defined:
  - A running 8-bit sum of every byte delivered for addresses 0..SIZE-1 is maintained. It is cleared on entry to PAUSE.
  - A read at ioctl_addr==SIZE returns the two's-complement of the sum (payload + checksum byte == 0 mod 256), without a RAM access. Addresses > SIZE return 8'hFF.
  - Re-reading an address adds it to the sum again; the HPS reads sequentially.
- Not defined: address SIZE returns 8'hFF like any out-of-range address; no sum logic is synthesised.

Test Plan:
- Non-matching index (index=0, upload=1) with rd strobes -> pause_req, ioctl_wait and ram_rd stay 0; busy=0.
- Matching upload, pause_ack delayed 5 cycles -> ioctl_wait=1 for those 5 cycles; first rd is accepted only after pause_ack.
- RAM preloaded with addr[7:0] ^ 8'h5A; sequential reads 0..SIZE-1 with ram_ack delays of 0..3 cycles -> each ioctl_din matches and ioctl_wait deasserts exactly one cycle after ram_ack.
- Reads at SIZE+7 -> ioctl_din=8'hFF, no ram_rd, ioctl_wait never asserted.
- Drop ioctl_upload during FETCH before ram_ack -> next cycle ram_rd=0, pause_req=0, ioctl_wait=0, state IDLE; a later ram_ack produces no change to ioctl_din.
- With IOCTL_UPLOAD_CHECKSUM_EN, RAM all 8'h01, SIZE=1024 -> read at 1024 returns 8'h00; with RAM 0..2 = 1,2,3 and the rest 0 -> returns 8'hFA.

Source files
------------

// File: rtl/ioctl_upload.sv
// ioctl_upload: serves HPS save-file uploads by reading bytes
// from game RAM and returning them on the ioctl upload path.
//
// Optional build macro: IOCTL_UPLOAD_CHECKSUM_EN
//   When defined, a read at address SIZE returns the two's
//   complement of the 8-bit sum of all bytes delivered since
//   the upload started, so payload + checksum == 0 mod 256.
//   When undefined, address SIZE reads as 8'hFF.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_ioctl_upload      HPS upload in progress
//   i_ioctl_index       file index of the transfer
//   i_ioctl_addr        byte address, valid with i_ioctl_rd
//   i_ioctl_rd          single-cycle read strobe
//   o_ioctl_din         byte returned to the HPS
//   o_ioctl_wait        stalls the HPS while a byte is fetched
//   o_pause_req         asks the game core to halt
//   i_pause_ack         game core is halted
//   o_ram_addr          game RAM byte address
//   o_ram_rd            RAM read request, held until i_ram_ack
//   i_ram_ack           RAM strobe, i_ram_q valid with it
//   i_ram_q             RAM read data
//   o_busy              matching upload in progress
module ioctl_upload #(
    parameter int INDEX      = 4,
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ioctl_upload,
    input  logic [7:0]            i_ioctl_index,
    input  logic [24:0]           i_ioctl_addr,
    input  logic                  i_ioctl_rd,
    output logic [7:0]            o_ioctl_din,
    output logic                  o_ioctl_wait,
    output logic                  o_pause_req,
    input  logic                  i_pause_ack,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_rd,
    input  logic                  i_ram_ack,
    input  logic [7:0]            i_ram_q,
    output logic                  o_busy
);

    localparam logic [24:0] LP_SIZE  = 25'(SIZE);
    localparam logic [7:0]  LP_INDEX = 8'(INDEX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAUSE,
        S_READY,
        S_FETCH
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_din, w_din_nxt;
    logic                  r_wait, w_wait_nxt;
    logic                  r_pause_req, w_pause_req_nxt;
    logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
    logic                  r_ram_rd, w_ram_rd_nxt;
    logic                  r_busy, w_busy_nxt;

    logic w_match;
    logic w_in_range;
    logic w_rd_fetch;
    logic w_wait_early;

    assign w_match    = i_ioctl_upload && (i_ioctl_index == LP_INDEX);
    // Full 25-bit compare: upper address bits must not alias
    // back into the RAM window.
    assign w_in_range = (i_ioctl_addr < LP_SIZE);
    assign w_rd_fetch = (r_state == S_READY) && i_ioctl_rd && w_in_range;

    // The HPS must see wait in the very cycle it is needed: when
    // the upload starts and when an in-range read is accepted.
    assign w_wait_early = !i_reset && w_match &&
                          ((r_state == S_IDLE) || w_rd_fetch);

`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    logic [7:0] r_sum, w_sum_nxt;
    logic       w_is_sum;

    assign w_is_sum = (i_ioctl_addr == LP_SIZE);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_din_nxt       = r_din;
        w_wait_nxt      = r_wait;
        w_pause_req_nxt = r_pause_req;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_rd_nxt    = r_ram_rd;
        w_busy_nxt      = r_busy;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        w_sum_nxt       = r_sum;
`endif
        if (!w_match) begin
            // Upload ended (or never matched): release the game
            // and the HPS from any state, dropping a pending fetch.
            w_state_nxt     = S_IDLE;
            w_wait_nxt      = 1'b0;
            w_pause_req_nxt = 1'b0;
            w_ram_rd_nxt    = 1'b0;
            w_busy_nxt      = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt     = S_PAUSE;
                    w_busy_nxt      = 1'b1;
                    w_pause_req_nxt = 1'b1;
                    w_wait_nxt      = 1'b1;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
                    w_sum_nxt       = 8'h00;
`endif
                end
                S_PAUSE: begin
                    if (i_pause_ack) begin
                        w_state_nxt = S_READY;
                        w_wait_nxt  = 1'b0;
                    end
                end
                S_READY: begin
                    if (i_ioctl_rd) begin
                        if (w_in_range) begin
                            w_state_nxt    = S_FETCH;
                            w_ram_addr_nxt = i_ioctl_addr[ADDR_WIDTH-1:0];
                            w_ram_rd_nxt   = 1'b1;
                            w_wait_nxt     = 1'b1;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
                        end else if (w_is_sum) begin
                            w_din_nxt = 8'h00 - r_sum;
`endif
                        end else begin
                            w_din_nxt = 8'hFF;
                        end
                    end
                end
                S_FETCH: begin
                    if (i_ram_ack) begin
                        w_state_nxt  = S_READY;
                        w_din_nxt    = i_ram_q;
                        w_ram_rd_nxt = 1'b0;
                        w_wait_nxt   = 1'b0;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
                        w_sum_nxt    = r_sum + i_ram_q;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_din       <= 8'h00;
            r_wait      <= 1'b0;
            r_pause_req <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_rd    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_din       <= w_din_nxt;
            r_wait      <= w_wait_nxt;
            r_pause_req <= w_pause_req_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_rd    <= w_ram_rd_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sum <= 8'h00;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    assign o_ioctl_din  = r_din;
    assign o_ioctl_wait = r_wait | w_wait_early;
    assign o_pause_req  = r_pause_req;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_rd     = r_ram_rd;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_ioctl_upload.sv
// tb_ioctl_upload: randomized self-checking bench for ioctl_upload
// against a byte-level model of the save region.
`timescale 1ns/1ps
module tb_ioctl_upload;

    localparam int INDEX = 4;
    localparam int SIZE  = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          upload;
    logic [7:0]    index;
    logic [24:0]   addr;
    logic          rd;
    logic [7:0]    din;
    logic          ioctl_wait;
    logic          pause_req;
    logic          pause_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic          ram_ack;
    logic [7:0]    ram_q;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [SIZE];
    logic [7:0] m_sum;
    logic [7:0] m_din;

    ioctl_upload #(
        .INDEX(INDEX),
        .SIZE(SIZE),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_ioctl_upload(upload),
        .i_ioctl_index(index),
        .i_ioctl_addr(addr),
        .i_ioctl_rd(rd),
        .o_ioctl_din(din),
        .o_ioctl_wait(ioctl_wait),
        .o_pause_req(pause_req),
        .i_pause_ack(pause_ack),
        .o_ram_addr(ram_addr),
        .o_ram_rd(ram_rd),
        .i_ram_ack(ram_ack),
        .i_ram_q(ram_q),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Byte the HPS should receive for a given address.
    function automatic logic [7:0] model_byte(input logic [24:0] a);
        logic [AW-1:0] i;
        i = a[AW-1:0];
        if (a < 25'(SIZE)) return mem[i];
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        if (a == 25'(SIZE)) return 8'h00 - m_sum;
`endif
        return 8'hFF;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        upload = 1'b1;
        index = 8'(INDEX);
        tick();
        tick();
        smp();
        n_cmp++;
        if (din !== 8'h00 || ioctl_wait !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data din=%h wait=%b exp 00/0", din, ioctl_wait);
        end
        n_cmp++;
        if ({pause_req, ram_rd, busy} !== 3'b000 || ram_addr !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl prb=%b addr=%h exp 000/0",
                     {pause_req, ram_rd, busy}, ram_addr);
        end
        tick();
        reset = 1'b0;
        upload = 1'b0;
        m_din = 8'h00;
    endtask

    task automatic test_nomatch();
        tick();
        upload = 1'b1;
        index = 8'h00;
        for (int k = 0; k < 12; k++) begin
            rd = 1'($urandom_range(0, 1));
            addr = 25'($urandom_range(0, 1100));
            smp();
            n_cmp++;
            if ({pause_req, ioctl_wait, ram_rd, busy} !== 4'b0000) begin
                n_err++;
                $display("FAIL nomatch pwrb=%b exp 0000",
                         {pause_req, ioctl_wait, ram_rd, busy});
            end
            tick();
        end
        rd = 1'b0;
        upload = 1'b0;
        smp();
        n_cmp++;
        if (din !== m_din) begin
            n_err++;
            $display("FAIL nomatch_din got=%h exp=%h", din, m_din);
        end
    endtask

    task automatic test_pause(input int pd, input bit inject);
        m_sum = 8'h00;
        tick();
        upload = 1'b1;
        index = 8'(INDEX);
        rd = 1'b0;
        pause_ack = 1'b0;
        smp();
        n_cmp++;
        if (ioctl_wait !== 1'b1) begin
            n_err++;
            $display("FAIL pause_start_wait got=%b exp=1", ioctl_wait);
        end
        for (int k = 0; k < pd; k++) begin
            tick();
            rd = inject && (k == 1);
            addr = 25'd3;
            smp();
            n_cmp++;
            if ({ioctl_wait, pause_req, busy, ram_rd} !== 4'b1110) begin
                n_err++;
                $display("FAIL pause_hold k=%0d wprb=%b exp 1110", k,
                         {ioctl_wait, pause_req, busy, ram_rd});
            end
        end
        tick();
        rd = 1'b0;
        pause_ack = 1'b1;
        smp();
        n_cmp++;
        if (ioctl_wait !== 1'b1) begin
            n_err++;
            $display("FAIL pause_ack_cycle wait=%b exp=1", ioctl_wait);
        end
        tick();
        smp();
        n_cmp++;
        if ({ioctl_wait, pause_req, busy, ram_rd} !== 4'b0110) begin
            n_err++;
            $display("FAIL pause_ready wprb=%b exp 0110",
                     {ioctl_wait, pause_req, busy, ram_rd});
        end
    endtask

    task automatic test_read(input logic [24:0] a, input int dly);
        logic [7:0] exp;
        bit         inr;
        inr = (a < 25'(SIZE));
        exp = model_byte(a);
        tick();
        rd = 1'b1;
        addr = a;
        smp();
        n_cmp++;
        if (ioctl_wait !== inr) begin
            n_err++;
            $display("FAIL read_wait_accept a=%h got=%b exp=%b", a, ioctl_wait, inr);
        end
        tick();
        rd = 1'b0;
        addr = 25'($urandom);
        if (inr) begin
            for (int k = 0; k <= dly; k++) begin
                if (k == dly) begin
                    ram_ack = 1'b1;
                    ram_q = mem[a[AW-1:0]];
                end
                smp();
                n_cmp++;
                if (ram_rd !== 1'b1 || ram_addr !== a[AW-1:0] || ioctl_wait !== 1'b1) begin
                    n_err++;
                    $display("FAIL read_fetch a=%h rd=%b addr=%h wait=%b exp 1/%h/1",
                             a, ram_rd, ram_addr, ioctl_wait, a[AW-1:0]);
                end
                tick();
                ram_ack = 1'b0;
                ram_q = 8'($urandom);
            end
            m_sum = m_sum + exp;
        end
        smp();
        n_cmp++;
        if (din !== exp) begin
            n_err++;
            $display("FAIL read_data a=%h got=%h exp=%h", a, din, exp);
        end
        n_cmp++;
        if (ioctl_wait !== 1'b0 || ram_rd !== 1'b0) begin
            n_err++;
            $display("FAIL read_done a=%h wait=%b rd=%b exp 0/0", a, ioctl_wait, ram_rd);
        end
        m_din = exp;
    endtask

    task automatic test_sequential(input int maxd);
        for (int a = 0; a < SIZE; a++) begin
            test_read(25'(a), $urandom_range(0, maxd));
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic test_out_of_range();
        test_read(25'(SIZE + 7), 0);
        test_read(25'(SIZE), 0);
        test_read(25'(SIZE + 1), 0);
        test_read(25'h1000000, 0);
        test_read(25'(SIZE - 1), 2);
        test_read(25'h1FFFFFF, 0);
    endtask

    task automatic test_end();
        tick();
        upload = 1'b0;
        tick();
        pause_ack = 1'b0;
        smp();
        n_cmp++;
        if ({pause_req, ioctl_wait, ram_rd, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL end_release pwrb=%b exp 0000",
                     {pause_req, ioctl_wait, ram_rd, busy});
        end
    endtask

    task automatic test_abort();
        test_pause(2, 1'b0);
        test_read(25'd17, 1);
        tick();
        rd = 1'b1;
        addr = 25'd100;
        tick();
        rd = 1'b0;
        smp();
        n_cmp++;
        if (ram_rd !== 1'b1) begin
            n_err++;
            $display("FAIL abort_fetch ram_rd=%b exp=1", ram_rd);
        end
        tick();
        upload = 1'b0;
        tick();
        smp();
        n_cmp++;
        if ({pause_req, ioctl_wait, ram_rd, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_release pwrb=%b exp 0000",
                     {pause_req, ioctl_wait, ram_rd, busy});
        end
        tick();
        ram_ack = 1'b1;
        ram_q = ~m_din;
        tick();
        ram_ack = 1'b0;
        pause_ack = 1'b0;
        smp();
        n_cmp++;
        if (din !== m_din || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_late_ack din=%h busy=%b exp %h/0", din, busy, m_din);
        end
    endtask

    task automatic test_reset_mid();
        test_pause(1, 1'b0);
        tick();
        rd = 1'b1;
        addr = 25'd5;
        tick();
        rd = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        smp();
        n_cmp++;
        if ({pause_req, ioctl_wait, ram_rd, busy} !== 4'b0000 || din !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid pwrb=%b din=%h exp 0000/00",
                     {pause_req, ioctl_wait, ram_rd, busy}, din);
        end
        tick();
        reset = 1'b0;
        upload = 1'b0;
        pause_ack = 1'b0;
        m_din = 8'h00;
        tick();
    endtask

    task automatic test_checksum();
        for (int i = 0; i < SIZE; i++) mem[i] = 8'h01;
        test_pause(0, 1'b0);
        test_sequential(0);
        test_read(25'(SIZE), 0);
        test_end();
        for (int i = 0; i < SIZE; i++) mem[i] = 8'h00;
        mem[0] = 8'h01;
        mem[1] = 8'h02;
        mem[2] = 8'h03;
        test_pause(3, 1'b0);
        test_sequential(1);
        test_read(25'(SIZE), 0);
        test_end();
    endtask

    initial begin
        reset = 1'b1;
        upload = 1'b0;
        index = 8'h00;
        addr = '0;
        rd = 1'b0;
        pause_ack = 1'b0;
        ram_ack = 1'b0;
        ram_q = 8'h00;
        m_sum = 8'h00;
        m_din = 8'h00;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'(i) ^ 8'h5A;

        test_reset();
        test_nomatch();
        test_pause(5, 1'b1);
        test_sequential(3);
        test_out_of_range();
        test_end();
        test_abort();
        test_reset_mid();
        test_checksum();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
